// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous block RAM between the CPU memory path
//   and the video/IO read requester. Each granted request becomes one 3-cycle
//   RAM access (IDLE -> ACCESS -> RESP). The CPU wins ties by default. A
//   starvation counter forces a video grant once the CPU has won MAX_WAIT ties
//   in a row.
//
// Ports
//   clk, reset                 clock (rising edge), synchronous active-low reset
//   cpu_req/we/addr/wdata      CPU request; held until cpu_ack
//   cpu_ack, cpu_rvalid        completion pulse; rvalid only for CPU reads
//   cpu_rdata                  RAM read data, valid while cpu_rvalid
//   vid_req/addr               video read request; held until vid_ack
//   vid_ack, vid_rdata         completion pulse with read data
//   mem_en/we/addr/wdata       registered RAM controls
//   mem_rdata                  RAM read data, valid the cycle after mem_en
module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // MAX_WAIT = 0 would give a zero-width counter; keep one bit that stays 0.
  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_waitCnt;
  logic              r_ownerVid;
  logic              r_memEn;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic              r_cpuAck;
  logic              r_cpuRvalid;
  logic              r_vidAck;

  logic w_anyReq;
  logic w_grantVid;

  assign w_anyReq = cpu_req | vid_req;

  // Video wins when it is alone, or on a tie once the CPU has won MAX_WAIT
  // ties. With MAX_WAIT = 0 the counter is stuck at 0, so video wins every tie.
  assign w_grantVid = vid_req & (~cpu_req | (r_waitCnt == MAX_CNT));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_waitCnt   <= '0;
      r_ownerVid  <= 1'b0;
      r_memEn     <= 1'b0;
      r_memWe     <= 1'b0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_cpuAck    <= 1'b0;
      r_cpuRvalid <= 1'b0;
      r_vidAck    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cpuAck    <= 1'b0;
          r_cpuRvalid <= 1'b0;
          r_vidAck    <= 1'b0;
          if (w_anyReq) begin
            r_ownerVid <= w_grantVid;
            r_memEn    <= 1'b1;
            // A video owner can never write, whatever cpu_we is doing.
            r_memWe    <= ~w_grantVid & cpu_we;
            r_memAddr  <= w_grantVid ? vid_addr : cpu_addr;
            r_memWdata <= w_grantVid ? '0 : cpu_wdata;
            // The CPU can only win a tie while the counter is below MAX_CNT,
            // so the increment never overflows past MAX_WAIT.
            if (w_grantVid) begin
              r_waitCnt <= '0;
            end else if (vid_req) begin
              r_waitCnt <= r_waitCnt + CNT_W'(1);
            end
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          r_memEn     <= 1'b0;
          r_memWe     <= 1'b0;
          r_cpuAck    <= ~r_ownerVid;
          // r_memWe still holds the latched write flag on this edge.
          r_cpuRvalid <= ~r_ownerVid & ~r_memWe;
          r_vidAck    <= r_ownerVid;
          r_state     <= RESP;
        end
        RESP: begin
          r_cpuAck    <= 1'b0;
          r_cpuRvalid <= 1'b0;
          r_vidAck    <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_memEn     <= 1'b0;
          r_memWe     <= 1'b0;
          r_cpuAck    <= 1'b0;
          r_cpuRvalid <= 1'b0;
          r_vidAck    <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign mem_en     = r_memEn;
  assign mem_we     = r_memWe;
  assign mem_addr   = r_memAddr;
  assign mem_wdata  = r_memWdata;
  assign cpu_ack    = r_cpuAck;
  assign cpu_rvalid = r_cpuRvalid;
  assign vid_ack    = r_vidAck;
  assign cpu_rdata  = mem_rdata;
  assign vid_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a small synchronous RAM model
//   attached to the mem_* port. Inputs change and outputs are sampled on the
//   falling clock edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int testsRun  = 0;
  int failCount = 0;

  mem_port_arbiter #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .MAX_WAIT(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_ack   (vid_ack),
    .vid_rdata (vid_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model: read data appears the cycle after mem_en.
  // The preload happens on the first edge, long before reset is released.
  logic [15:0] ram [0:1023];
  logic        ramInit = 1'b0;

  always @(posedge clk) begin
    if (!ramInit) begin
      ram[16'h0010] <= 16'hBEEF;
      ram[16'h0100] <= 16'h00FF;
      ramInit       <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[9:0]];
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [15:0] cAddr,
                               input logic [15:0] cData, input logic vReq, input logic [15:0] vAddr);
    cpu_req   = cReq;
    cpu_we    = cWe;
    cpu_addr  = cAddr;
    cpu_wdata = cData;
    vid_req   = vReq;
    vid_addr  = vAddr;
  endtask

  // Expected owner of each grant while both requests are held (MAX_WAIT = 4):
  // four CPU grants, then one forced video grant, then the CPU again.
  logic expVid [0:5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    repeat (3) tick();

    // Reset state
    checkBit ("rst_mem_en",  mem_en,     1'b0);
    checkBit ("rst_mem_we",  mem_we,     1'b0);
    checkWord("rst_addr",    mem_addr,   16'h0000);
    checkBit ("rst_cpu_ack", cpu_ack,    1'b0);
    checkBit ("rst_rvalid",  cpu_rvalid, 1'b0);
    checkBit ("rst_vid_ack", vid_ack,    1'b0);
    reset = 1'b1;
    tick();

    // T1: CPU read of preloaded 0x0010
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000);
    tick();
    checkBit ("t1_mem_en",  mem_en,   1'b1);
    checkBit ("t1_mem_we",  mem_we,   1'b0);
    checkWord("t1_addr",    mem_addr, 16'h0010);
    checkBit ("t1_noack",   cpu_ack,  1'b0);
    tick();
    checkBit ("t1_ack",     cpu_ack,    1'b1);
    checkBit ("t1_rvalid",  cpu_rvalid, 1'b1);
    checkWord("t1_rdata",   cpu_rdata,  16'hBEEF);
    checkBit ("t1_en_off",  mem_en,     1'b0);
    cpu_req = 1'b0;
    tick();
    checkBit ("t1_ack_end", cpu_ack, 1'b0);

    // T2: CPU write then read back
    applyStimulus(1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0000);
    tick();
    checkBit ("t2_w_en",    mem_en,    1'b1);
    checkBit ("t2_w_we",    mem_we,    1'b1);
    checkWord("t2_w_wdata", mem_wdata, 16'h1234);
    tick();
    checkBit ("t2_w_ack",    cpu_ack,    1'b1);
    checkBit ("t2_w_rvalid", cpu_rvalid, 1'b0);
    cpu_req = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000);
    tick();
    checkBit ("t2_r_we", mem_we, 1'b0);
    tick();
    checkBit ("t2_r_ack",    cpu_ack,    1'b1);
    checkBit ("t2_r_rvalid", cpu_rvalid, 1'b1);
    checkWord("t2_r_rdata",  cpu_rdata,  16'h1234);
    cpu_req = 1'b0;
    tick();

    // T3: simultaneous requests, counter at 0 -> CPU first, video 3 cycles later
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h0100);
    tick();
    checkWord("t3_cpu_addr", mem_addr, 16'h0010);
    tick();
    checkBit ("t3_cpu_ack",  cpu_ack, 1'b1);
    checkBit ("t3_vid_wait", vid_ack, 1'b0);
    cpu_req = 1'b0;
    tick();
    tick();
    checkWord("t3_vid_addr", mem_addr, 16'h0100);
    checkBit ("t3_vid_we",   mem_we,   1'b0);
    tick();
    checkBit ("t3_vid_ack",   vid_ack,   1'b1);
    checkBit ("t3_cpu_quiet", cpu_ack,   1'b0);
    checkWord("t3_vid_rdata", vid_rdata, 16'h00FF);
    vid_req = 1'b0;
    tick();

    // T4: both held high -> C C C C V C
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h0100);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkBit("t4_mem_we", mem_we, 1'b0);
      tick();
      checkBit($sformatf("t4_cpu_ack%0d", k), cpu_ack, ~expVid[k]);
      checkBit($sformatf("t4_vid_ack%0d", k), vid_ack,  expVid[k]);
      if (k == 5) begin
        cpu_req = 1'b0;
        vid_req = 1'b0;
      end
      tick();
    end

    // T5: reset during ACCESS aborts the read
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000);
    tick();
    checkBit("t5_en_access", mem_en, 1'b1);
    reset = 1'b0;
    tick();
    checkBit ("t5_no_ack",    cpu_ack,    1'b0);
    checkBit ("t5_no_rvalid", cpu_rvalid, 1'b0);
    checkBit ("t5_en_zero",   mem_en,     1'b0);
    checkWord("t5_addr_zero", mem_addr,   16'h0000);
    reset = 1'b1;
    tick();
    checkBit("t5_regrant_en", mem_en, 1'b1);
    tick();
    checkBit ("t5_regrant_ack", cpu_ack,   1'b1);
    checkWord("t5_rdata",       cpu_rdata, 16'hBEEF);
    cpu_req = 1'b0;
    tick();

    // T6: lone video read at 0x0100
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'hAAAA, 1'b1, 16'h0100);
    tick();
    checkBit ("t6_en",   mem_en,   1'b1);
    checkBit ("t6_we",   mem_we,   1'b0);
    checkWord("t6_addr", mem_addr, 16'h0100);
    tick();
    checkBit ("t6_ack",     vid_ack,   1'b1);
    checkBit ("t6_cpu_ack", cpu_ack,   1'b0);
    checkBit ("t6_we_resp", mem_we,    1'b0);
    checkWord("t6_rdata",   vid_rdata, 16'h00FF);
    vid_req = 1'b0;
    tick();
    checkBit("t6_ack_end", vid_ack, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
